// File: rtl/btn_seq_pkg.sv
// ============================================================================
// Module   : btn_seq_pkg
// Brief    : Shared state encoding and constants for the button-driven EEPROM
//            test sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package btn_seq_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] S_WR_REQ = 3'd1;
  localparam logic [STATE_W-1:0] S_WR_DLY = 3'd2;
  localparam logic [STATE_W-1:0] S_RD_REQ = 3'd3;
  localparam logic [STATE_W-1:0] S_CHECK  = 3'd4;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // 5 ms write time and 10 ms request timeout at 10 MHz
  localparam int DEF_WR_DELAY_CYC = 50000;
  localparam int DEF_TIMEOUT_CYC  = 100000;

endpackage

`default_nettype wire

// File: rtl/btn_eeprom_sequencer_timer.sv
// ============================================================================
// Module   : seq_timer
// Brief    : Loadable down-counter that stops at zero; shared by the write
//            delay and the request timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_timer #(
  parameter int WIDTH = 17
) (
  input  logic             i_Clock10MHz,
  input  logic             i_Rst,
  input  logic             i_Load,
  input  logic [WIDTH-1:0] i_Load_Val,
  input  logic             i_En,
  output logic             o_Zero
);

  logic [WIDTH-1:0] r_Count;

  always_ff @(posedge i_Clock10MHz) begin
    if (i_Rst) begin
      r_Count <= '0;
    end else if (i_Load) begin
      r_Count <= i_Load_Val;
    end else if (i_En && (r_Count != '0)) begin
      r_Count <= r_Count - WIDTH'(1);
    end
  end

  assign o_Zero = (r_Count == '0);

endmodule

`default_nettype wire

// File: rtl/btn_eeprom_sequencer.sv
// ============================================================================
// Module   : btn_eeprom_sequencer
// Brief    : Turns debounced press pulses into EEPROM write/verify or read-only
//            transactions over a req/done handshake; sticky LED status.
//            Optional macro BTN_SEQ_PRESS_QUEUE_EN adds a one-deep press latch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_eeprom_sequencer
  import btn_seq_pkg::*;
#(
  parameter int                ADDR_W       = 8,
  parameter int                DATA_W       = 8,
  parameter logic [ADDR_W-1:0] START_ADDR   = '0,
  parameter logic [DATA_W-1:0] START_DATA   = DATA_W'(8'hA5),
  parameter int                WR_DELAY_CYC = DEF_WR_DELAY_CYC,
  parameter int                TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
  input  logic              i_Clock10MHz,
  input  logic              i_Rst,
  input  logic              i_Press_Pulse,
  input  logic              i_Mode,
  output logic              o_Req,
  output logic              o_Rw,
  output logic [ADDR_W-1:0] o_Addr,
  output logic [DATA_W-1:0] o_Wdata,
  input  logic              i_Done,
  input  logic              i_Nack,
  input  logic [DATA_W-1:0] i_Rdata,
  output logic              o_Busy,
  output logic              o_Pass,
  output logic              o_Fail,
  output logic              o_Timeout,
  output logic [DATA_W-1:0] o_Last_Rdata
);

  localparam int                 TMR_W      = $clog2(TIMEOUT_CYC + 1);
  // Loaded with N-1 so the zero flag is seen on exactly the Nth edge
  localparam logic [TMR_W-1:0]   c_TMO_LOAD = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0]   c_DLY_LOAD = TMR_W'(WR_DELAY_CYC - 1);

  logic [STATE_W-1:0] r_State;
  logic               r_Req;
  logic               r_Rw;
  logic               r_Mode;
  logic [ADDR_W-1:0]  r_Addr;
  logic [DATA_W-1:0]  r_Pattern;
  logic               r_Pass;
  logic               r_Fail;
  logic               r_Timeout;
  logic [DATA_W-1:0]  r_Last_Rdata;

  logic               w_Start;
  logic               w_Start_Mode;
  logic               w_Tmr_Load;
  logic [TMR_W-1:0]   w_Tmr_Val;
  logic               w_Tmr_En;
  logic               w_Tmr_Zero;
  logic               w_Idle;

  assign w_Idle = (r_State == S_IDLE);

`ifdef BTN_SEQ_PRESS_QUEUE_EN
  logic r_Pending;
  logic r_Pend_Mode;

  // A pending press is served on the first IDLE cycle, ahead of any new press
  always_ff @(posedge i_Clock10MHz) begin
    if (i_Rst) begin
      r_Pending   <= 1'b0;
      r_Pend_Mode <= 1'b0;
    end else if (w_Idle && r_Pending) begin
      r_Pending   <= 1'b0;
    end else if (!w_Idle && i_Press_Pulse && !r_Pending) begin
      r_Pending   <= 1'b1;
      r_Pend_Mode <= i_Mode;
    end
  end

  assign w_Start      = w_Idle && (i_Press_Pulse || r_Pending);
  assign w_Start_Mode = r_Pending ? r_Pend_Mode : i_Mode;
`else
  assign w_Start      = w_Idle && i_Press_Pulse;
  assign w_Start_Mode = i_Mode;
`endif

  always_comb begin
    w_Tmr_Load = 1'b0;
    w_Tmr_Val  = c_TMO_LOAD;
    case (r_State)
      S_WR_REQ: begin
        if (!r_Req) begin
          w_Tmr_Load = 1'b1;
        end else if (i_Done && !i_Nack) begin
          w_Tmr_Load = 1'b1;
          w_Tmr_Val  = c_DLY_LOAD;
        end
      end
      S_RD_REQ: begin
        if (!r_Req) begin
          w_Tmr_Load = 1'b1;
        end
      end
      S_WR_DLY: begin
        if (w_Tmr_Zero) begin
          w_Tmr_Load = 1'b1;
        end
      end
      default: begin
        w_Tmr_Load = 1'b0;
      end
    endcase
  end

  assign w_Tmr_En = !w_Idle;

  seq_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .i_Clock10MHz (i_Clock10MHz),
    .i_Rst        (i_Rst),
    .i_Load       (w_Tmr_Load),
    .i_Load_Val   (w_Tmr_Val),
    .i_En         (w_Tmr_En),
    .o_Zero       (w_Tmr_Zero)
  );

  always_ff @(posedge i_Clock10MHz) begin
    if (i_Rst) begin
      r_State      <= S_IDLE;
      r_Req        <= 1'b0;
      r_Rw         <= RW_WRITE;
      r_Mode       <= 1'b0;
      r_Addr       <= START_ADDR;
      r_Pattern    <= START_DATA;
      r_Pass       <= 1'b0;
      r_Fail       <= 1'b0;
      r_Timeout    <= 1'b0;
      r_Last_Rdata <= '0;
    end else begin
      case (r_State)
        S_IDLE: begin
          if (w_Start) begin
            r_Pass    <= 1'b0;
            r_Fail    <= 1'b0;
            r_Timeout <= 1'b0;
            r_Mode    <= w_Start_Mode;
            r_Rw      <= w_Start_Mode ? RW_READ : RW_WRITE;
            r_State   <= w_Start_Mode ? S_RD_REQ : S_WR_REQ;
          end
        end

        S_WR_REQ: begin
          if (!r_Req) begin
            r_Req <= 1'b1;
          end else if (i_Done) begin
            r_Req <= 1'b0;
            if (i_Nack) begin
              r_Fail  <= 1'b1;
              r_State <= S_IDLE;
            end else begin
              r_State <= S_WR_DLY;
            end
          end else if (w_Tmr_Zero) begin
            r_Req     <= 1'b0;
            r_Timeout <= 1'b1;
            r_State   <= S_IDLE;
          end
        end

        // The read request goes out on the same edge the delay expires
        S_WR_DLY: begin
          if (w_Tmr_Zero) begin
            r_Req   <= 1'b1;
            r_Rw    <= RW_READ;
            r_State <= S_RD_REQ;
          end
        end

        S_RD_REQ: begin
          if (!r_Req) begin
            r_Req <= 1'b1;
          end else if (i_Done) begin
            r_Req        <= 1'b0;
            r_Last_Rdata <= i_Rdata;
            if (i_Nack) begin
              r_Fail  <= 1'b1;
              r_State <= S_IDLE;
            end else begin
              r_State <= S_CHECK;
            end
          end else if (w_Tmr_Zero) begin
            r_Req     <= 1'b0;
            r_Timeout <= 1'b1;
            r_State   <= S_IDLE;
          end
        end

        S_CHECK: begin
          r_State <= S_IDLE;
          if (!r_Mode && (r_Last_Rdata != r_Pattern)) begin
            r_Fail <= 1'b1;
          end else begin
            r_Pass <= 1'b1;
            r_Addr <= r_Addr + ADDR_W'(1);
            if (!r_Mode) begin
              r_Pattern <= r_Pattern + DATA_W'(1);
            end
          end
        end

        default: begin
          r_State <= S_IDLE;
          r_Req   <= 1'b0;
        end
      endcase
    end
  end

  assign o_Req        = r_Req;
  assign o_Rw         = r_Rw;
  assign o_Addr       = r_Addr;
  assign o_Wdata      = r_Pattern;
  assign o_Busy       = !w_Idle;
  assign o_Pass       = r_Pass;
  assign o_Fail       = r_Fail;
  assign o_Timeout    = r_Timeout;
  assign o_Last_Rdata = r_Last_Rdata;

endmodule

`default_nettype wire

// File: tb/tb_btn_eeprom_sequencer.sv
// ============================================================================
// Module   : tb_btn_eeprom_sequencer
// Brief    : Randomized scoreboard bench for btn_eeprom_sequencer with a
//            behavioural master responder and transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_eeprom_sequencer;

  localparam int WRD = 20;
  localparam int TMO = 50;

  logic       clk = 1'b0;
  logic       i_Rst, i_Press_Pulse, i_Mode, i_Done, i_Nack;
  logic [7:0] i_Rdata;
  logic       o_Req, o_Rw, o_Busy, o_Pass, o_Fail, o_Timeout;
  logic [7:0] o_Addr, o_Wdata, o_Last_Rdata;

  always #50 clk = ~clk;

  btn_eeprom_sequencer #(
    .WR_DELAY_CYC (WRD),
    .TIMEOUT_CYC  (TMO)
  ) dut (
    .i_Clock10MHz (clk),
    .i_Rst        (i_Rst),
    .i_Press_Pulse(i_Press_Pulse),
    .i_Mode       (i_Mode),
    .o_Req        (o_Req),
    .o_Rw         (o_Rw),
    .o_Addr       (o_Addr),
    .o_Wdata      (o_Wdata),
    .i_Done       (i_Done),
    .i_Nack       (i_Nack),
    .i_Rdata      (i_Rdata),
    .o_Busy       (o_Busy),
    .o_Pass       (o_Pass),
    .o_Fail       (o_Fail),
    .o_Timeout    (o_Timeout),
    .o_Last_Rdata (o_Last_Rdata)
  );

  typedef struct {
    bit         rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         len;
    int         gap;
    bit         lat;
  } req_t;

  typedef struct {
    bit         pass;
    bit         fail;
    bit         tmo;
    logic [7:0] rd;
    int         lag;
  } stat_t;

  req_t  q_req[$];
  stat_t q_stat[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int press_cyc = 0;
  bit mon_en = 1'b0;

  // Master responder knobs
  bit         m_nodone = 1'b0;
  bit         m_wr_nack = 1'b0;
  bit         m_rd_nack = 1'b0;
  int         m_delay = 1;
  logic [7:0] m_rdata = 8'h00;

  // Reference model state
  logic [7:0] mdl_addr = 8'h00;
  logic [7:0] mdl_pat = 8'hA5;
  logic [7:0] mdl_last = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin : master
    int age;
    age = 0;
    i_Done = 1'b0;
    i_Nack = 1'b0;
    i_Rdata = 8'h00;
    forever begin
      @(negedge clk);
      i_Done = 1'b0;
      i_Nack = 1'b0;
      if (o_Req) begin
        age++;
        if (!m_nodone && age == m_delay) begin
          i_Done  = 1'b1;
          i_Nack  = o_Rw ? m_rd_nack : m_wr_nack;
          i_Rdata = o_Rw ? m_rdata : 8'h00;
        end
      end else begin
        age = 0;
      end
    end
  end

  int bfall_cyc = 0;
  int brise_gap = 0;

  initial begin : monitor
    req_t  cur;
    stat_t s;
    bit    have_cur, prev_req, prev_busy;
    int    rise_cyc, fall_cyc;
    have_cur = 0; prev_req = 0; prev_busy = 0; rise_cyc = 0; fall_cyc = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (o_Req && !prev_req) begin
          checks++;
          if (q_req.size() == 0) begin
            errors++;
            have_cur = 0;
            $display("FAIL req_unexpected: got rw=%0d addr=%0h, expected no request", o_Rw, o_Addr);
          end else begin
            cur = q_req.pop_front();
            have_cur = 1;
            if (cur.gap >= 0) chk("wr_delay_gap", cyc - fall_cyc, cur.gap);
            if (cur.lat) chk("press_latency", cyc - press_cyc, 2);
          end
          rise_cyc = cyc;
        end
        if (o_Req && have_cur) begin
          chk("req_rw", o_Rw, cur.rw);
          chk("req_addr", o_Addr, cur.addr);
          if (!cur.rw) chk("req_wdata", o_Wdata, cur.wdata);
        end
        if (!o_Req && prev_req) begin
          fall_cyc = cyc;
          if (have_cur) chk("req_len", cyc - rise_cyc, cur.len);
          have_cur = 0;
        end
        if (o_Busy && !prev_busy) begin
          brise_gap = cyc - bfall_cyc;
          chk("flags_cleared", {o_Pass, o_Fail, o_Timeout}, 3'b000);
        end
        if (!o_Busy && prev_busy) begin
          bfall_cyc = cyc;
          checks++;
          if (q_stat.size() == 0) begin
            errors++;
            $display("FAIL seq_unexpected: got sequence end, expected none");
          end else begin
            s = q_stat.pop_front();
            chk("pass", o_Pass, s.pass);
            chk("fail", o_Fail, s.fail);
            chk("timeout", o_Timeout, s.tmo);
            chk("last_rdata", o_Last_Rdata, s.rd);
            chk("busy_lag", cyc - fall_cyc, s.lag);
          end
        end
      end
      prev_req = o_Req;
      prev_busy = o_Busy;
    end
  end

  // kind: 0 read returns pattern, 1 write NACK, 2 read NACK, 3 no done, 4 read returns rdv
  task automatic expect_seq(input bit mode, input int kind, input int d,
                            input logic [7:0] rdv, input bit lat);
    req_t  r;
    stat_t s;
    bit    ok;
    ok = 1;
    if (kind == 3) begin
      r = '{mode, mdl_addr, mdl_pat, TMO, -1, lat};
      q_req.push_back(r);
      s = '{0, 0, 1, mdl_last, 0};
    end else begin
      if (!mode) begin
        r = '{0, mdl_addr, mdl_pat, d, -1, lat};
        q_req.push_back(r);
        if (kind == 1) ok = 0;
      end
      if (ok) begin
        r = '{1, mdl_addr, mdl_pat, d, mode ? -1 : WRD, mode ? lat : 1'b0};
        q_req.push_back(r);
        mdl_last = rdv;
        if (kind == 2) ok = 0;
      end
      if (!ok) begin
        s = '{0, 1, 0, mdl_last, 0};
      end else if (mode || rdv == mdl_pat) begin
        s = '{1, 0, 0, rdv, 1};
        mdl_addr = mdl_addr + 8'd1;
        if (!mode) mdl_pat = mdl_pat + 8'd1;
      end else begin
        s = '{0, 1, 0, rdv, 1};
      end
    end
    q_stat.push_back(s);
  endtask

  task automatic press(input bit mode);
    @(negedge clk);
    i_Press_Pulse = 1'b1;
    i_Mode = mode;
    press_cyc = cyc;
    @(negedge clk);
    i_Press_Pulse = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((o_Busy || q_stat.size() != 0) && n < budget);
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL idle_wait: got busy after %0d cycles, expected idle", n);
      q_req.delete();
      q_stat.delete();
    end
  endtask

  task automatic setup_master(input bit mode, input int kind, input int d,
                              input logic [7:0] rd, output logic [7:0] rdv);
    rdv = (kind == 0 && !mode) ? mdl_pat : rd;
    m_delay = d;
    m_rdata = rdv;
    m_nodone = (kind == 3);
    m_wr_nack = (kind == 1);
    m_rd_nack = (kind == 2);
  endtask

  task automatic run_seq(input bit mode, input int kind, input int d, input logic [7:0] rd);
    logic [7:0] rdv;
    setup_master(mode, kind, d, rd, rdv);
    expect_seq(mode, kind, d, rdv, 1);
    press(mode);
    wait_idle(600);
  endtask

  task automatic wait_req(input bit level, input int budget);
    int n;
    n = 0;
    while (o_Req !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("req_wait", o_Req, level);
  endtask

  initial begin : driver
    logic [7:0] rdv;
    int k, kind;
    i_Rst = 1'b1;
    i_Press_Pulse = 1'b0;
    i_Mode = 1'b0;
    repeat (3) @(negedge clk);
    i_Rst = 1'b0;
    @(negedge clk);
    chk("rst_req", o_Req, 0);
    chk("rst_rw", o_Rw, 0);
    chk("rst_busy", o_Busy, 0);
    chk("rst_status", {o_Pass, o_Fail, o_Timeout}, 3'b000);
    chk("rst_last_rdata", o_Last_Rdata, 8'h00);
    chk("rst_addr", o_Addr, 8'h00);
    chk("rst_wdata", o_Wdata, 8'hA5);
    mon_en = 1'b1;

    run_seq(0, 0, 3, 8'h00);
    chk("t1_pass_led", o_Pass, 1);
    run_seq(0, 0, 2, 8'h00);
    run_seq(0, 4, 4, 8'h00);
    run_seq(0, 0, 1, 8'h00);
    run_seq(0, 1, 2, 8'h00);
    run_seq(0, 3, 1, 8'h00);
    run_seq(1, 3, 1, 8'h00);
    run_seq(0, 0, TMO, 8'h00);
    run_seq(1, 2, 3, 8'h5A);

    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 9);
      kind = (k <= 4) ? 0 : (k <= 6) ? 4 : (k == 7) ? 1 : (k == 8) ? 2 : 3;
      run_seq(1'($urandom_range(0, 1)), kind, $urandom_range(1, 6), 8'($urandom));
    end

    // Reset during an outstanding read, with a simultaneous press
    mon_en = 1'b0;
    m_nodone = 1'b1;
    press(1);
    wait_req(1'b1, 10);
    repeat (3) @(negedge clk);
    i_Rst = 1'b1;
    i_Press_Pulse = 1'b1;
    @(negedge clk);
    i_Rst = 1'b0;
    i_Press_Pulse = 1'b0;
    chk("rst_mid_req", o_Req, 0);
    chk("rst_mid_busy", o_Busy, 0);
    chk("rst_mid_status", {o_Pass, o_Fail, o_Timeout}, 3'b000);
    chk("rst_mid_last", o_Last_Rdata, 8'h00);
    q_req.delete();
    q_stat.delete();
    mdl_addr = 8'h00;
    mdl_pat = 8'hA5;
    mdl_last = 8'h00;
    m_nodone = 1'b0;
    @(negedge clk);
    chk("rst_press_ignored", o_Busy, 0);
    mon_en = 1'b1;

    for (int i = 0; i < 256; i++) begin
      run_seq(1, 0, $urandom_range(1, 4), 8'($urandom));
    end
    run_seq(0, 0, 2, 8'h00);

    // Press during the write delay
    setup_master(0, 0, 3, 8'h00, rdv);
    expect_seq(0, 0, 3, rdv, 1);
    press(0);
    wait_req(1'b1, 10);
    wait_req(1'b0, 10);
    repeat (5) @(negedge clk);
`ifdef BTN_SEQ_PRESS_QUEUE_EN
    expect_seq(1, 0, 3, rdv, 0);
`endif
    press(1);
    wait_idle(600);
`ifdef BTN_SEQ_PRESS_QUEUE_EN
    chk("queued_start_gap", brise_gap, 1);
`else
    repeat (10) @(negedge clk);
    chk("busy_press_ignored", o_Busy, 0);
    chk("no_extra_req", q_req.size(), 0);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
